// File: rtl/laser_pkg.sv
// Shared types, default sizes and helpers for the laser fire scheduler.
package laser_pkg;

  localparam int unsigned DefCntW   = 16;
  localparam int unsigned DefShotW  = 12;
  localparam int unsigned DefMinGap = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFire = 2'd1,
    StGap  = 2'd2,
    StDone = 2'd3
  } state_e;

  // max(a, b) clamped to the largest w-bit unsigned value (w < 64).
  function automatic longint unsigned sat_max(input longint unsigned a,
                                              input longint unsigned b,
                                              input int unsigned     w);
    longint unsigned lim;
    longint unsigned m;
    lim = (64'd1 << w) - 64'd1;
    m   = (a > b) ? a : b;
    return (m > lim) ? lim : m;
  endfunction

endpackage

// File: rtl/fire_timer.sv
// Period and width counters for one shot; both restart from zero on load_i.
module fire_timer #(
  parameter int unsigned CntW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [CntW-1:0] width_i,
  input  logic [CntW-1:0] period_i,
  output logic            width_done_o,
  output logic            period_tc_o
);

  logic [CntW-1:0] pcnt_q, pcnt_d;
  logic [CntW-1:0] wcnt_q, wcnt_d;

  // Counters saturate so a stalled count can never wrap back into range.
  always_comb begin
    pcnt_d = pcnt_q;
    wcnt_d = wcnt_q;
    if (load_i) begin
      pcnt_d = '0;
      wcnt_d = '0;
    end else begin
      if (!(&pcnt_q)) pcnt_d = pcnt_q + CntW'(1);
      if (!(&wcnt_q)) wcnt_d = wcnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pcnt_q <= '0;
      wcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      wcnt_q <= wcnt_d;
    end
  end

  // width_i and period_i are never zero once latched.
  assign width_done_o = (wcnt_q >= (width_i - CntW'(1)));
  assign period_tc_o  = (pcnt_q >= (period_i - CntW'(1)));

endmodule

// File: rtl/laser_fire_sched.sv
// Per-revolution laser shot scheduler: bursts of send_en pulses after a zero-index start.
module laser_fire_sched
  import laser_pkg::*;
#(
  parameter int unsigned CntW   = DefCntW,
  parameter int unsigned ShotW  = DefShotW,
  parameter int unsigned MinGap = DefMinGap
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [CntW-1:0]  cfg_period_i,
  input  logic [CntW-1:0]  cfg_width_i,
  input  logic [ShotW-1:0] cfg_shots_i,
  output logic             send_en_o,
  output logic [ShotW-1:0] shot_idx_o,
  output logic             shot_start_o,
  output logic             busy_o,
  output logic             scan_done_o,
  output logic             overrun_o
);

  state_e state_q, state_d;

  logic [CntW-1:0]  width_q, width_d, period_q, period_d;
  logic [ShotW-1:0] shots_q, shots_d, shot_idx_q, shot_idx_d;
  logic             send_en_q, send_en_d, shot_start_q, shot_start_d;
  logic             busy_q, busy_d, scan_done_q, scan_done_d, overrun_q, overrun_d;
  logic             stop_pend_q, stop_pend_d;

  logic             accept, load, more_shots, width_done, period_tc;
  logic [CntW-1:0]  eff_width, eff_period;
  logic [ShotW:0]   idx_next_ext;

  assign eff_width  = (cfg_width_i == '0) ? CntW'(1) : cfg_width_i;
  assign eff_period = CntW'(sat_max(64'(cfg_period_i), 64'(eff_width) + 64'(MinGap), CntW));

  assign accept       = (state_q == StIdle) && start_i && !stop_i;
  assign idx_next_ext = (ShotW+1)'(shot_idx_q) + (ShotW+1)'(1);
  assign more_shots   = (shots_q == '0) || (idx_next_ext < (ShotW+1)'(shots_q));

  fire_timer #(
    .CntW(CntW)
  ) u_fire_timer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (load),
    .width_i     (width_q),
    .period_i    (period_q),
    .width_done_o(width_done),
    .period_tc_o (period_tc)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (accept) state_d = StFire;
      // A pending stop never truncates the pulse; it only ends the scan after it.
      StFire: if (width_done) state_d = (stop_i || stop_pend_q) ? StIdle : StGap;
      StGap: begin
        if (stop_i)         state_d = StIdle;
        else if (period_tc) state_d = more_shots ? StFire : StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    load         = (state_d == StFire) && (state_q != StFire);
    shot_idx_d   = shot_idx_q;
    if (load) shot_idx_d = (state_q == StIdle) ? '0 : shot_idx_q + ShotW'(1);
    send_en_d    = (state_d == StFire);
    shot_start_d = load;
    busy_d       = (state_d != StIdle);
    scan_done_d  = (state_d == StDone);
    overrun_d    = start_i && (state_q != StIdle);
    stop_pend_d  = (state_d == StFire) && (stop_pend_q || stop_i);
    width_d      = accept ? eff_width : width_q;
    period_d     = accept ? eff_period : period_q;
    shots_d      = accept ? cfg_shots_i : shots_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      width_q      <= CntW'(1);
      period_q     <= CntW'(1);
      shots_q      <= '0;
      shot_idx_q   <= '0;
      send_en_q    <= 1'b0;
      shot_start_q <= 1'b0;
      busy_q       <= 1'b0;
      scan_done_q  <= 1'b0;
      overrun_q    <= 1'b0;
      stop_pend_q  <= 1'b0;
    end else begin
      width_q      <= width_d;
      period_q     <= period_d;
      shots_q      <= shots_d;
      shot_idx_q   <= shot_idx_d;
      send_en_q    <= send_en_d;
      shot_start_q <= shot_start_d;
      busy_q       <= busy_d;
      scan_done_q  <= scan_done_d;
      overrun_q    <= overrun_d;
      stop_pend_q  <= stop_pend_d;
    end
  end

  assign send_en_o    = send_en_q;
  assign shot_idx_o   = shot_idx_q;
  assign shot_start_o = shot_start_q;
  assign busy_o       = busy_q;
  assign scan_done_o  = scan_done_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_laser_fire_sched.sv
// Scoreboard bench: expected output events are queued up front, a negedge monitor pops them.
module tb_laser_fire_sched;

  localparam int unsigned CntW   = 16;
  localparam int unsigned ShotW  = 3;
  localparam int unsigned MinGap = 4;

  typedef enum int {EvRise, EvFall, EvDone, EvOvr} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       cyc;
    int       idx;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             start_i = 1'b0;
  logic             stop_i = 1'b0;
  logic [CntW-1:0]  cfg_period_i = '0;
  logic [CntW-1:0]  cfg_width_i = '0;
  logic [ShotW-1:0] cfg_shots_i = '0;
  logic             send_en_o, shot_start_o, busy_o, scan_done_o, overrun_o;
  logic [ShotW-1:0] shot_idx_o;

  ev_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   base = 0;
  logic send_prev = 1'b0;

  laser_fire_sched #(
    .CntW  (CntW),
    .ShotW (ShotW),
    .MinGap(MinGap)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .cfg_period_i(cfg_period_i),
    .cfg_width_i (cfg_width_i),
    .cfg_shots_i (cfg_shots_i),
    .send_en_o   (send_en_o),
    .shot_idx_o  (shot_idx_o),
    .shot_start_o(shot_start_o),
    .busy_o      (busy_o),
    .scan_done_o (scan_done_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d required finish earlier", cyc);
    $fatal(1, "watchdog expired");
  end

  // Cycle c of a scan is the interval sampled at negedge with cyc == base + c.
  task automatic expect_ev(input ev_kind_e k, input int c, input int idx);
    ev_t e;
    e.kind = k;
    e.cyc  = base + c;
    e.idx  = idx;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_e k, input int idx);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event got %s cyc=%0d idx=%0d required none", k.name(), cyc, idx);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || (k == EvRise && e.idx != idx)) begin
        errors++;
        $display("FAIL event got %s cyc=%0d idx=%0d required %s cyc=%0d idx=%0d",
                 k.name(), cyc, idx, e.kind.name(), e.cyc, e.idx);
      end
    end
  endtask

  always @(negedge clk) begin
    if (shot_start_o) observe(EvRise, int'(shot_idx_o));
    if (send_prev && !send_en_o) observe(EvFall, 0);
    if (scan_done_o) observe(EvDone, 0);
    if (overrun_o) observe(EvOvr, 0);
    send_prev <= send_en_o;
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, want);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < base + c) @(negedge clk);
  endtask

  task automatic launch(input int p, input int w, input int s);
    @(negedge clk);
    cfg_period_i = CntW'(p);
    cfg_width_i  = CntW'(w);
    cfg_shots_i  = ShotW'(s);
    start_i      = 1'b1;
    base         = cyc;
  endtask

  task automatic release_start();
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic drain(input string name, input int c);
    wait_to(c);
    chk({name, "_missing_events"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_send_en"}, int'(send_en_o), 0);
    chk({name, "_shot_idx"}, int'(shot_idx_o), 0);
    chk({name, "_shot_start"}, int'(shot_start_o), 0);
    chk({name, "_busy"}, int'(busy_o), 0);
    chk({name, "_scan_done"}, int'(scan_done_o), 0);
    chk({name, "_overrun"}, int'(overrun_o), 0);
  endtask

  task automatic basic_burst(input string name);
    launch(10, 3, 4);
    for (int k = 0; k < 4; k++) begin
      expect_ev(EvRise, 1 + 10 * k, k);
      expect_ev(EvFall, 4 + 10 * k, 0);
    end
    expect_ev(EvDone, 41, 0);
    release_start();
    wait_to(41);
    chk({name, "_busy_in_done"}, int'(busy_o), 1);
    wait_to(42);
    chk({name, "_busy_after"}, int'(busy_o), 0);
    chk({name, "_idx_hold"}, int'(shot_idx_o), 3);
    drain(name, 45);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_ni = 1'b1;
    @(negedge clk);

    basic_burst("basic");

    // Width 0 clamps to 1, period 2 clamps to 1 + MinGap.
    launch(2, 0, 2);
    expect_ev(EvRise, 1, 0);
    expect_ev(EvFall, 2, 0);
    expect_ev(EvRise, 6, 1);
    expect_ev(EvFall, 7, 0);
    expect_ev(EvDone, 11, 0);
    release_start();
    wait_to(12);
    chk("clamp_busy_after", int'(busy_o), 0);
    drain("clamp", 14);

    launch(20, 8, 4);
    expect_ev(EvRise, 1, 0);
    expect_ev(EvFall, 9, 0);
    release_start();
    wait_to(3);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    wait_to(8);
    chk("stop_pulse_kept", int'(send_en_o), 1);
    wait_to(9);
    chk("stop_busy_after", int'(busy_o), 0);
    drain("stop", 30);

    // start and stop together in IDLE: stop wins, no scan, no overrun.
    @(negedge clk);
    start_i = 1'b1;
    stop_i  = 1'b1;
    base    = cyc;
    @(negedge clk);
    start_i = 1'b0;
    stop_i  = 1'b0;
    wait_to(5);
    chk("idle_startstop_busy", int'(busy_o), 0);
    drain("idle_startstop", 6);

    launch(10, 3, 4);
    for (int k = 0; k < 4; k++) begin
      expect_ev(EvRise, 1 + 10 * k, k);
      if (k == 2) expect_ev(EvOvr, 23, 0);
      expect_ev(EvFall, 4 + 10 * k, 0);
    end
    expect_ev(EvDone, 41, 0);
    release_start();
    wait_to(5);
    cfg_period_i = CntW'(30);
    cfg_width_i  = CntW'(7);
    wait_to(22);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_to(42);
    chk("overrun_busy_after", int'(busy_o), 0);
    drain("overrun", 45);

    launch(6, 2, 0);
    for (int k = 0; k < 10; k++) begin
      expect_ev(EvRise, 1 + 6 * k, k % 8);
      expect_ev(EvFall, 3 + 6 * k, 0);
    end
    release_start();
    wait_to(58);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    wait_to(60);
    chk("wrap_busy_after_stop", int'(busy_o), 0);
    drain("wrap", 70);

    launch(10, 3, 4);
    expect_ev(EvRise, 1, 0);
    expect_ev(EvFall, 4, 0);
    expect_ev(EvRise, 11, 1);
    expect_ev(EvFall, 13, 0);
    release_start();
    wait_to(12);
    rst_ni = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midreset");
    rst_ni = 1'b1;
    drain("midreset", 15);

    basic_burst("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/laser_fire_sched.md
Name: laser_fire_sched

Overview:
- Schedules laser shots for one scan revolution. On a motor zero-index start pulse it emits a burst of send_en pulses with programmable width, period and shot count.
- Sits between the motor/encoder sync logic and the send pulse stage, which edge-detects send_en into the single-cycle laser trigger.
- Enforces a minimum low time between pulses for laser-driver safety.
- Reports per-shot index and scan completion to the range-capture path.

Parameters:
- CNT_W, 16: width of the period and width counters and of the cfg_period / cfg_width inputs.
- SHOT_W, 12: width of the shot counter, cfg_shots and shot_idx.
- MIN_GAP, 4: minimum send_en low cycles between consecutive pulses (≥1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous to clk, active-low
- start  in  1  single-cycle scan start (motor zero index)
- stop  in  1  single-cycle abort request
- cfg_period  in  CNT_W  shot period in clk cycles
- cfg_width  in  CNT_W  send_en high time in clk cycles
- cfg_shots  in  SHOT_W  shots per scan; 0 = continuous until stop
- send_en  out  1  laser fire level to the send pulse stage
- shot_idx  out  SHOT_W  index of current/last shot
- shot_start  out  1  one-cycle pulse coincident with each send_en rise
- busy  out  1  high in any state except IDLE
- scan_done  out  1  one-cycle pulse after the last shot period completes normally
- overrun  out  1  one-cycle pulse when start arrives while busy

Behaviour:
- Reset (rst_n low at a clk edge) forces IDLE. Outputs on reset: send_en=0, shot_idx=0, shot_start=0, busy=0, scan_done=0, overrun=0. All counters clear. A reset mid-pulse drops send_en on the next edge.
- All outputs are registered.
- States: IDLE, FIRE, GAP, DONE.
- Config latch: on start accepted in IDLE, latch cfg_* into shadow registers. Later cfg_* changes have no effect until the next start.
  - eff_width = max(cfg_width, 1).
  - eff_period = max(cfg_period, eff_width + MIN_GAP), computed at CNT_W+1 bits and saturated to 2^CNT_W−1.
- IDLE → FIRE: start=1 sampled at edge n gives send_en=1, shot_start=1, busy=1, shot_idx=0 at edge n+1. Latency is one cycle.
- FIRE: send_en stays high for exactly eff_width cycles, then the state moves to GAP. The period counter runs from the first FIRE cycle.
- GAP: send_en=0. When the period counter reaches eff_period−1:
  - If more shots remain (cfg_shots=0, or shot_idx < cfg_shots−1): increment shot_idx and return to FIRE with shot_start=1. Pulses are back-to-back at exactly eff_period cycles rise-to-rise.
  - Otherwise go to DONE.
- DONE: one cycle, scan_done=1, then IDLE. busy is high in DONE and falls on entry to IDLE.
- Continuous mode: shot_idx wraps from 2^SHOT_W−1 to 0 and the scan continues.
- stop:
  - In GAP or DONE: go to IDLE on the next edge, no scan_done.
  - In FIRE: the current pulse completes its full eff_width (never truncated), then IDLE, no scan_done.
  - In IDLE: ignored.
- start while busy: ignored, overrun=1 for one cycle.
- start and stop in the same cycle in IDLE: stop wins, and the block stays in IDLE.
- start and stop in the same cycle while busy: overrun pulses and the stop rules above apply.
- cfg_shots=1: one pulse, then DONE after eff_period cycles.
- shot_idx holds its last value in IDLE until the next accepted start.

Decomposition:
- Shared package laser_pkg holds:
  - state encoding constants (ST_IDLE, ST_FIRE, ST_GAP, ST_DONE);
  - default CNT_W, SHOT_W and MIN_GAP;
  - the saturating max helper function.
- One natural sub-module: fire_timer, holding the period/width counters with load, terminal-count and width-done outputs.
- The FSM, shot counter and flag pulses stay in the top module.

Test Plan:
- Basic burst: period=10, width=3, shots=4, start at cycle 0. Expect send_en high cycles 1–3, 11–13, 21–23, 31–33; shot_idx 0..3; scan_done at cycle 41; busy low from cycle 42.
- Clamping: width=0, period=2, MIN_GAP=4, shots=2. Expect 1-cycle pulses with rise-to-rise spacing 5; scan_done after the second period.
- Stop mid-pulse: width=8, period=20, stop asserted in the 3rd FIRE cycle. Expect the full 8-cycle pulse, then IDLE, no scan_done, and no further send_en.
- Overrun and config isolation: second start at shot 2, plus a cfg_period change mid-scan. Expect one overrun pulse, and timing unchanged at the original period.
- Continuous wrap: SHOT_W=3, shots=0, period=6, width=2. Expect shot_idx sequence 0..7,0,1… until stop; no scan_done.
- Reset mid-operation: rst_n low during FIRE at shot 1. Expect send_en=0 and all outputs at reset values at the next edge; a fresh start afterwards behaves as the basic burst.
